// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: states, opcodes, functs, ALU ops and mux selects.
package ctrl_pkg;

  typedef enum logic [4:0] {
    S_RESET      = 5'd0,
    S_FETCH      = 5'd1,
    S_FETCH_WAIT = 5'd2,
    S_IR_LOAD    = 5'd3,
    S_DECODE     = 5'd4,
    S_R_EXEC     = 5'd5,
    S_R_WB       = 5'd6,
    S_ADDI_EXEC  = 5'd7,
    S_ADDI_WB    = 5'd8,
    S_MEM_ADDR   = 5'd9,
    S_LW_READ    = 5'd10,
    S_LW_WAIT    = 5'd11,
    S_LW_WB      = 5'd12,
    S_SW_WRITE   = 5'd13,
    S_BRANCH     = 5'd14,
    S_JUMP       = 5'd15,
    S_JAL        = 5'd16,
    S_JR         = 5'd17,
    S_ILLEGAL    = 5'd18
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // REG_DST_SP is reserved for future stack ops
  localparam logic [1:0] REG_DST_RD = 2'b00;
  localparam logic [1:0] REG_DST_RA = 2'b01;
  localparam logic [1:0] REG_DST_SP = 2'b10;
  localparam logic [1:0] REG_DST_RT = 2'b11;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  function automatic logic [2:0] funct_to_alu_op(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Memory-latency countdown shared by instruction fetch and lw; done flags the last wait cycle.
module mem_wait_counter #(
  parameter int WAIT_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              dec,
  input  logic [WAIT_W-1:0] load_val,
  output logic              done
);

  logic [WAIT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == WAIT_W'(1));

endmodule

// File: rtl/ctrl_multiciclo_fsm.sv
// Moore control FSM for the multicycle MIPS-subset datapath; outputs follow state,
// except pc_write, which also ORs in the beq/bne taken condition.
module ctrl_multiciclo_fsm
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int WAIT_W   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic [4:0] state_dbg
);

  localparam logic [WAIT_W-1:0] MEM_WAIT_V = WAIT_W'(MEM_WAIT);
  localparam bit                NO_WAIT    = (MEM_WAIT == 0);

  state_t state_q, state_d;
  logic   cnt_load, cnt_dec, cnt_done;
  logic   pc_write_base, taken;

  mem_wait_counter #(.WAIT_W(WAIT_W)) u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (MEM_WAIT_V),
    .done     (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;
    pc_write_base = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = REG_DST_RD;
    mem_to_reg    = M2R_ALUOUT;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    illegal       = 1'b0;

    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        cnt_load = 1'b1;
        state_d  = NO_WAIT ? S_IR_LOAD : S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_done) state_d = S_IR_LOAD;
      end
      S_IR_LOAD: begin
        ir_write      = 1'b1;
        alu_src_b     = 2'b01;
        pc_write_base = 1'b1;
        state_d       = S_DECODE;
      end
      S_DECODE: begin
        // Speculative branch target lands in ALUOut while the opcode is dispatched
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE: begin
            case (funct)
              FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: state_d = S_R_EXEC;
              FN_JR:   state_d = S_JR;
              default: state_d = S_ILLEGAL;
            endcase
          end
          OP_J:           state_d = S_JUMP;
          OP_JAL:         state_d = S_JAL;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDI_EXEC;
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          default:        state_d = S_ILLEGAL;
        endcase
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = funct_to_alu_op(funct);
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        reg_dst   = REG_DST_RT;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? S_SW_WRITE : S_LW_READ;
      end
      S_LW_READ: begin
        iord     = 1'b1;
        cnt_load = 1'b1;
        state_d  = NO_WAIT ? S_LW_WB : S_LW_WAIT;
      end
      S_LW_WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_done) state_d = S_LW_WB;
      end
      S_LW_WB: begin
        reg_write  = 1'b1;
        reg_dst    = REG_DST_RT;
        mem_to_reg = M2R_MDR;
        state_d    = S_FETCH;
      end
      S_SW_WRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write_base = 1'b1;
        pc_source     = PCSRC_JUMP;
        state_d       = S_FETCH;
      end
      S_JAL: begin
        reg_write     = 1'b1;
        reg_dst       = REG_DST_RA;
        mem_to_reg    = M2R_PC;
        pc_write_base = 1'b1;
        pc_source     = PCSRC_JUMP;
        state_d       = S_FETCH;
      end
      S_JR: begin
        pc_write_base = 1'b1;
        pc_source     = PCSRC_REG;
        state_d       = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign taken     = (opcode == OP_BNE) ? ~zero : zero;
  assign pc_write  = pc_write_base | (pc_write_cond & taken);
  assign state_dbg = state_q;

endmodule

// File: doc/ctrl_multiciclo_fsm.md
Name: ctrl_multiciclo_fsm

Overview:
Main control unit of the multicycle RISC processor. A Moore FSM that sequences fetch, decode, execute, memory and write-back for the supported MIPS subset. It drives every datapath select and write enable, including the 2-bit register-destination select of the write-back mux. It handles a configurable memory latency with an internal wait counter.

Parameters:
MEM_WAIT, 1, extra cycles between presenting a memory address and read data being valid (0..7)
WAIT_W, 3, width of the wait counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
opcode  in  6  instr[31:26] from IR
funct  in  6  instr[5:0] from IR
zero  in  1  ALU zero flag
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if branch condition holds (internal gating, see Behaviour)
iord  out  1  memory address select: 0=PC, 1=ALUOut
mem_write  out  1  memory write strobe
ir_write  out  1  IR load
reg_write  out  1  register-file write enable
reg_dst  out  2  write-register select: 00=rd field, 01=const 31, 10=const 29, 11=rt field
mem_to_reg  out  2  write data: 00=ALUOut, 01=MDR, 10=PC
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  out  3  ALU function code (package constants)
pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=A (jr)
illegal  out  1  one-cycle pulse on an unsupported opcode/funct
state_dbg  out  5  current state encoding

Behaviour:
- One clock domain. At a posedge with reset=1: state<=S_RESET, wait counter<=0. In S_RESET all outputs are 0. Reset held keeps S_RESET. The first cycle after release goes to S_FETCH. Reset mid-instruction aborts with no write strobes in the reset cycle.
- Outputs are a pure function of state (Moore). Exception: pc_write is effectively pc_write | (pc_write_cond & branch_taken), where taken = zero for beq and ~zero for bne. The combined value is presented on pc_write. pc_write_cond is exported for debug.
- Every non-driven output defaults to 0.
- S_FETCH: iord=0, counter<=MEM_WAIT. If MEM_WAIT=0 go directly to S_IR_LOAD, else S_FETCH_WAIT.
- S_FETCH_WAIT: decrement the counter. Leave when counter==1. This gives exactly MEM_WAIT cycles in the state.
- S_IR_LOAD: ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00, pc_write=1.
- S_DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target into ALUOut). Dispatch on opcode:
  - 0x00 R-type: funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A go to S_R_EXEC. jr 0x08 goes to S_JR.
  - 0x02 j: S_JUMP.
  - 0x03 jal: S_JAL.
  - 0x04/0x05 beq/bne: S_BRANCH.
  - 0x08 addi: S_ADDI_EXEC.
  - 0x23/0x2B lw/sw: S_MEM_ADDR.
  - Anything else: S_ILLEGAL.
- S_R_EXEC: alu_src_a=1, alu_src_b=00, alu_op from funct. Next S_R_WB.
- S_R_WB: reg_write=1, reg_dst=00, mem_to_reg=00.
- S_ADDI_EXEC: alu_src_a=1, alu_src_b=10, ADD. Next S_ADDI_WB.
- S_ADDI_WB: reg_write=1, reg_dst=11, mem_to_reg=00.
- S_MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. Go to S_LW_READ (lw) or S_SW_WRITE (sw).
- S_LW_READ: iord=1, counter<=MEM_WAIT. Then S_LW_WAIT, skipped when MEM_WAIT=0, using the same countdown rule as fetch. Then S_LW_WB.
- S_LW_WB: reg_write=1, reg_dst=11, mem_to_reg=01.
- S_SW_WRITE: iord=1, mem_write=1 for exactly one cycle.
- S_BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_write_cond=1, pc_source=01.
- S_JUMP: pc_write=1, pc_source=10.
- S_JAL: reg_write=1, reg_dst=01, mem_to_reg=10 (PC already +4), pc_write=1, pc_source=10.
- S_JR: pc_write=1, pc_source=11.
- S_ILLEGAL: illegal=1. No writes.
- All terminal states (R_WB, ADDI_WB, LW_WB, SW_WRITE, BRANCH, JUMP, JAL, JR, ILLEGAL) return to S_FETCH.
- reg_dst=10 (const 29) is reserved for stack ops and never driven in this revision.
- CPI, MEM_WAIT=0: R/addi 5, lw 6, sw 5, beq/bne/j/jal/jr 4, illegal 4. Each memory access adds MEM_WAIT.

Decomposition:
- Package ctrl_pkg holds:
  - state_t enum with fixed 5-bit encodings.
  - Opcode and funct localparams.
  - ALU op constants ADD=000, SUB=001, AND=010, OR=011, SLT=111.
  - reg_dst, mem_to_reg and pc_source encodings.
- One natural sub-module, mem_wait_counter: load, decrement, done flag. It is shared by fetch and lw.

Test Plan:
- Reset held 3 cycles during S_LW_WAIT -> state_dbg=S_RESET, all outputs 0; fetch starts 1 cycle after release.
- add (op 0x00, funct 0x20), MEM_WAIT=0 -> states FETCH, IR_LOAD, DECODE, R_EXEC, R_WB; R_WB has reg_write=1, reg_dst=00, mem_to_reg=00.
- lw, MEM_WAIT=2 -> 2 cycles each in FETCH_WAIT and LW_WAIT; LW_WB has reg_dst=11, mem_to_reg=01; 10 cycles total.
- beq with zero=1 then zero=0 -> pc_write=1 then 0 in S_BRANCH; bne gives the inverse; pc_source=01.
- jal -> single S_JAL cycle with reg_dst=01, mem_to_reg=10, reg_write=1, pc_write=1, pc_source=10.
- opcode 0x3F, then op 0x00 with funct 0x01 -> each gives a 1-cycle illegal pulse, no write strobes, then back to S_FETCH; sw gives exactly one mem_write cycle with iord=1.
